// File: rtl/bus_port_pkg.sv
// bus_port_pkg: constants shared by the per-core bus port front-end.
//   - request kind encodings (core_req_kind)
//   - FSM state encodings for core_bus_port
//   - default issue timeout (cycles), used by the optional watchdog
//   - small helpers to decode a request kind
package bus_port_pkg;

  localparam logic [1:0] KIND_DRAM_RD = 2'd0;
  localparam logic [1:0] KIND_DRAM_WR = 2'd1;
  localparam logic [1:0] KIND_DATA_RD = 2'd2;
  localparam logic [1:0] KIND_DATA_WR = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int BUSPORT_TIMEOUT_DEFAULT = 1024;

  // Kinds 0/1 target the dram channel, kinds 2/3 the data channel.
  function automatic logic kind_is_dram(input logic [1:0] kind);
    return ~kind[1];
  endfunction

  // Even kinds are reads.
  function automatic logic kind_is_read(input logic [1:0] kind);
    return ~kind[0];
  endfunction

endpackage

// File: rtl/busport_watchdog.sv
// busport_watchdog: issue-phase timeout for core_bus_port.
// Only instantiated when BUSPORT_TIMEOUT_EN is defined.
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   start     request accepted this cycle; reloads the counter
//   run       FSM is in ISSUE this cycle
//   expire    ISSUE has lasted TIMEOUT cycles (high during the last one)
// The counter is loaded with TIMEOUT-1 on accept and counts down once per
// ISSUE cycle, so expire is seen in the TIMEOUT-th ISSUE cycle.
module busport_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(TIMEOUT - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/core_bus_port.sv
// core_bus_port: per-core request front-end to the two-core bus arbiter.
// Turns a single-cycle valid/ready request from the core into a level-held
// le/we strobe, follows the arbiter busy handshake (rise = accepted,
// fall = done), captures read data and returns a one-cycle response.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   core_req_*                request from the core memory stage
//   core_rsp_*                one-cycle completion (data, timeout error)
//   bus_dram_*                dram channel toward the arbiter (port 0/1)
//   bus_data_*, bus_mem_paddr data channel toward the arbiter
// Build option: BUSPORT_TIMEOUT_EN adds a watchdog that aborts ISSUE after
// TIMEOUT cycles without busy, answering with core_rsp_err=1.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | ready for a request
// ST_ISSUE | strobe held, waiting for the selected busy to rise
// ST_WAIT  | strobe low, waiting for the selected busy to fall
// ST_RESP  | core_rsp_valid pulse
module core_bus_port
  import bus_port_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = BUSPORT_TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_req_kind,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  input  logic [2:0]        core_req_ctrl,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_data,
  output logic              core_rsp_err,
  output logic              bus_dram_le,
  output logic              bus_dram_we_t,
  output logic [ADDR_W-1:0] bus_dram_addr,
  output logic [DATA_W-1:0] bus_dram_wdata,
  output logic [2:0]        bus_dram_ctrl,
  input  logic              bus_dram_busy,
  input  logic [DATA_W-1:0] bus_dram_odata,
  output logic              bus_data_le,
  output logic              bus_data_we,
  output logic [ADDR_W-1:0] bus_mem_paddr,
  output logic [DATA_W-1:0] bus_data_wdata,
  input  logic [3:0]        bus_data_busy,
  input  logic [DATA_W-1:0] bus_data_data
);

  logic [1:0] state;
  logic [1:0] kind_q;
  logic       sel_busy;
  logic       accept;
  logic       wd_expire;

  assign core_req_ready = (state == ST_IDLE);
  assign accept         = core_req_ready && core_req_valid;
  assign sel_busy       = kind_is_dram(kind_q) ? bus_dram_busy : (|bus_data_busy);

`ifdef BUSPORT_TIMEOUT_EN
  busport_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .start  (accept),
    .run    (state == ST_ISSUE),
    .expire (wd_expire)
  );
`else
  // TIMEOUT only matters when the watchdog is built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
  assign core_rsp_err   = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= ST_IDLE;
      kind_q         <= KIND_DRAM_RD;
      bus_dram_le    <= 1'b0;
      bus_dram_we_t  <= 1'b0;
      bus_data_le    <= 1'b0;
      bus_data_we    <= 1'b0;
      bus_dram_addr  <= '0;
      bus_dram_wdata <= '0;
      bus_dram_ctrl  <= '0;
      bus_mem_paddr  <= '0;
      bus_data_wdata <= '0;
      core_rsp_valid <= 1'b0;
      core_rsp_data  <= '0;
`ifdef BUSPORT_TIMEOUT_EN
      core_rsp_err   <= 1'b0;
`endif
    end else begin
      core_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core_req_valid) begin
            kind_q <= core_req_kind;
            // Only the targeted channel's address/data registers change, so
            // the other channel keeps presenting its last request.
            if (kind_is_dram(core_req_kind)) begin
              bus_dram_addr  <= core_req_addr;
              bus_dram_wdata <= core_req_wdata;
              bus_dram_ctrl  <= core_req_ctrl;
            end else begin
              bus_mem_paddr  <= core_req_addr;
              bus_data_wdata <= core_req_wdata;
            end
            bus_dram_le   <= (core_req_kind == KIND_DRAM_RD);
            bus_dram_we_t <= (core_req_kind == KIND_DRAM_WR);
            bus_data_le   <= (core_req_kind == KIND_DATA_RD);
            bus_data_we   <= (core_req_kind == KIND_DATA_WR);
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sel_busy) begin
            bus_dram_le   <= 1'b0;
            bus_dram_we_t <= 1'b0;
            bus_data_le   <= 1'b0;
            bus_data_we   <= 1'b0;
            state         <= ST_WAIT;
          end else if (wd_expire) begin
            bus_dram_le    <= 1'b0;
            bus_dram_we_t  <= 1'b0;
            bus_data_le    <= 1'b0;
            bus_data_we    <= 1'b0;
            core_rsp_data  <= '0;
            core_rsp_valid <= 1'b1;
`ifdef BUSPORT_TIMEOUT_EN
            core_rsp_err   <= 1'b1;
`endif
            state          <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!sel_busy) begin
            case (kind_q)
              KIND_DRAM_RD: core_rsp_data <= bus_dram_odata;
              KIND_DATA_RD: core_rsp_data <= bus_data_data;
              default:      core_rsp_data <= '0;
            endcase
            core_rsp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end
        default: begin
`ifdef BUSPORT_TIMEOUT_EN
          core_rsp_err <= 1'b0;
`endif
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_port.sv
// tb_core_bus_port: directed scoreboard bench for core_bus_port.
// Stimulus pushes the expected response into exp_q; a negedge monitor pops
// and compares whenever core_rsp_valid is high.
module tb_core_bus_port;
  import bus_port_pkg::*;

`ifdef BUSPORT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        core_req_valid = 1'b0;
  logic        core_req_ready;
  logic [1:0]  core_req_kind = '0;
  logic [31:0] core_req_addr = '0;
  logic [31:0] core_req_wdata = '0;
  logic [2:0]  core_req_ctrl = '0;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_data;
  logic        core_rsp_err;
  logic        bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we;
  logic [31:0] bus_dram_addr, bus_dram_wdata, bus_mem_paddr, bus_data_wdata;
  logic [2:0]  bus_dram_ctrl;
  logic        bus_dram_busy = 1'b0;
  logic [31:0] bus_dram_odata = 32'hBAD0_0001;
  logic [3:0]  bus_data_busy = '0;
  logic [31:0] bus_data_data = 32'hBAD0_0002;
  logic [3:0]  strb;

  assign strb = {bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we};

  always #5 CLK = ~CLK;

  core_bus_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_kind(core_req_kind), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_ctrl(core_req_ctrl),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_err(core_rsp_err),
    .bus_dram_le(bus_dram_le), .bus_dram_we_t(bus_dram_we_t),
    .bus_dram_addr(bus_dram_addr), .bus_dram_wdata(bus_dram_wdata),
    .bus_dram_ctrl(bus_dram_ctrl), .bus_dram_busy(bus_dram_busy),
    .bus_dram_odata(bus_dram_odata),
    .bus_data_le(bus_data_le), .bus_data_we(bus_data_we),
    .bus_mem_paddr(bus_mem_paddr), .bus_data_wdata(bus_data_wdata),
    .bus_data_busy(bus_data_busy), .bus_data_data(bus_data_data)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Response monitor and strobe exclusivity check.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("strobe_onehot0", {63'd0, $onehot0(strb)}, 64'd1);
      if (core_rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {63'd0, core_rsp_valid}, 64'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", {32'd0, core_rsp_data}, {32'd0, e.data});
          chk("rsp_err", {63'd0, core_rsp_err}, {63'd0, e.err});
        end
      end
    end
  end

  task automatic chk_fields(input logic [1:0] kind, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ctrl);
    if (kind_is_dram(kind)) begin
      chk("dram_addr", {32'd0, bus_dram_addr}, {32'd0, addr});
      chk("dram_wdata", {32'd0, bus_dram_wdata}, {32'd0, wdata});
      chk("dram_ctrl", {61'd0, bus_dram_ctrl}, {61'd0, ctrl});
    end else begin
      chk("mem_paddr", {32'd0, bus_mem_paddr}, {32'd0, addr});
      chk("data_wdata", {32'd0, bus_data_wdata}, {32'd0, wdata});
    end
  endtask

  task automatic set_busy(input logic [1:0] kind, input logic [3:0] bpat);
    if (kind_is_dram(kind)) bus_dram_busy = (bpat != 4'd0);
    else                    bus_data_busy = bpat;
  endtask

  // One complete transaction with a scripted arbiter: busy rises `delay`
  // cycles after the strobe and is sampled high on `hold` edges. With poke
  // set, a competing request is held on core_req_valid while busy.
  task automatic run_txn(input logic [1:0] kind, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl,
                         input logic [31:0] rdata, input int delay,
                         input int hold, input logic [3:0] bpat, input bit poke);
    logic [3:0] exp_strb;
    rsp_t       e;
    exp_strb = 4'b1000 >> kind;
    chk("ready_idle", {63'd0, core_req_ready}, 64'd1);
    core_req_valid = 1'b1;
    core_req_kind  = kind;
    core_req_addr  = addr;
    core_req_wdata = wdata;
    core_req_ctrl  = ctrl;
    step();
    core_req_valid = 1'b0;
    e.data = kind_is_read(kind) ? rdata : 32'd0;
    e.err  = 1'b0;
    exp_q.push_back(e);
    chk("strobe_rise", {60'd0, strb}, {60'd0, exp_strb});
    chk_fields(kind, addr, wdata, ctrl);
    if (poke) begin
      core_req_valid = 1'b1;
      core_req_kind  = kind;
      core_req_addr  = 32'hFFFF_FFFC;
      core_req_wdata = 32'hFFFF_FFFF;
      core_req_ctrl  = 3'b111;
    end
    for (int i = 0; i < delay; i++) begin
      if (poke) chk("ready_busy_issue", {63'd0, core_req_ready}, 64'd0);
      step();
      chk("strobe_held", {60'd0, strb}, {60'd0, exp_strb});
    end
    set_busy(kind, bpat);
    for (int j = 0; j < hold; j++) begin
      step();
      chk("strobe_dropped", {60'd0, strb}, 64'd0);
      if (poke) chk("ready_busy_wait", {63'd0, core_req_ready}, 64'd0);
    end
    core_req_valid = 1'b0;
    set_busy(kind, 4'd0);
    if (kind_is_dram(kind)) bus_dram_odata = rdata;
    else                    bus_data_data  = rdata;
    step();
    chk("rsp_latency", {63'd0, core_rsp_valid}, 64'd1);
    bus_dram_odata = 32'hBAD0_0001;
    bus_data_data  = 32'hBAD0_0002;
    step();
    chk("rsp_one_cycle", {63'd0, core_rsp_valid}, 64'd0);
    chk("ready_after", {63'd0, core_req_ready}, 64'd1);
    chk_fields(kind, addr, wdata, ctrl);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    #2;
    chk("rst_strobes", {60'd0, strb}, 64'd0);
    chk("rst_rsp_valid", {63'd0, core_rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'd0, core_rsp_err}, 64'd0);
    chk("rst_rsp_data", {32'd0, core_rsp_data}, 64'd0);
    chk("rst_dram_addr", {32'd0, bus_dram_addr}, 64'd0);
    chk("rst_paddr", {32'd0, bus_mem_paddr}, 64'd0);
    #21;
    RST = 1'b0;
    step();
    chk("ready_after_rst", {63'd0, core_req_ready}, 64'd1);

    // dram read, busy rises 2 cycles after strobe and is held 4 cycles
    run_txn(KIND_DRAM_RD, 32'h8000_0100, 32'h0, 3'b010, 32'hDEAD_BEEF, 2, 4, 4'b0001, 1'b0);
    // data write, busy 4'b0001 for 3 cycles; read data bus carries garbage
    run_txn(KIND_DATA_WR, 32'h4000_0000, 32'h1234_5678, 3'b000, 32'h5555_AAAA, 1, 3, 4'b0001, 1'b0);
    // back-to-back: competing valid ignored, next request in RESP+1 cycle
    run_txn(KIND_DATA_RD, 32'h4000_0040, 32'h0, 3'b000, 32'hCAFE_F00D, 1, 2, 4'b0100, 1'b1);
    run_txn(KIND_DRAM_WR, 32'h8000_0200, 32'hA5A5_5A5A, 3'b101, 32'h5555_AAAA, 0, 2, 4'b0001, 1'b0);
    // data read with busy already high at strobe rise, upper busy bit only
    run_txn(KIND_DATA_RD, 32'h4000_0080, 32'h0, 3'b000, 32'h0BAD_CAFE, 0, 3, 4'b1000, 1'b0);

    // asynchronous reset during ISSUE of a dram write
    core_req_valid = 1'b1;
    core_req_kind  = KIND_DRAM_WR;
    core_req_addr  = 32'h8000_0300;
    core_req_wdata = 32'h7777_8888;
    core_req_ctrl  = 3'b011;
    step();
    core_req_valid = 1'b0;
    chk("rst_test_strobe", {60'd0, strb}, 64'b0100);
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("async_strobe_drop", {60'd0, strb}, 64'd0);
    #20;
    RST = 1'b0;
    step();
    chk("ready_after_midrst", {63'd0, core_req_ready}, 64'd1);
    chk("dram_addr_cleared", {32'd0, bus_dram_addr}, 64'd0);
    step();
    chk("no_strobe_after_rst", {60'd0, strb}, 64'd0);

    run_txn(KIND_DRAM_RD, 32'h8000_0400, 32'h0, 3'b001, 32'h1357_9BDF, 1, 2, 4'b0001, 1'b0);

    // busy never rises
    begin
      rsp_t e;
      core_req_valid = 1'b1;
      core_req_kind  = KIND_DATA_RD;
      core_req_addr  = 32'h4000_0100;
      core_req_wdata = 32'h0;
      step();
      core_req_valid = 1'b0;
`ifdef BUSPORT_TIMEOUT_EN
      e.data = 32'd0;
      e.err  = 1'b1;
      exp_q.push_back(e);
      for (int i = 0; i < TO; i++) begin
        chk("timeout_strobe_held", {60'd0, strb}, 64'b0010);
        step();
      end
      chk("timeout_strobe_drop", {60'd0, strb}, 64'd0);
      chk("timeout_rsp_valid", {63'd0, core_rsp_valid}, 64'd1);
      step();
      chk("timeout_ready", {63'd0, core_req_ready}, 64'd1);
      chk("timeout_err_cleared", {63'd0, core_rsp_err}, 64'd0);
`else
      e.data = 32'h2468_ACE0;
      e.err  = 1'b0;
      exp_q.push_back(e);
      for (int i = 0; i < 100; i++) step();
      chk("strobe_held_100", {60'd0, strb}, 64'b0010);
      bus_data_busy = 4'b0010;
      step();
      step();
      bus_data_busy = 4'b0000;
      bus_data_data = 32'h2468_ACE0;
      step();
      chk("late_rsp_valid", {63'd0, core_rsp_valid}, 64'd1);
      bus_data_data = 32'hBAD0_0002;
      step();
      chk("late_ready", {63'd0, core_req_ready}, 64'd1);
`endif
    end

    repeat (4) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
